// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and sends start, LSB-first
// data, optional parity and one or two stop bits, each bit 16 x16_BAUD ticks long.
module uart_tx #(
  parameter int P_DATA_BITS  = 8,
  parameter int P_STOP_BITS  = 1,
  parameter int P_PARITY_EN  = 0,
  parameter int P_PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       x16_BAUD,
  input  logic [7:0] Di,
  input  logic       valid,
  output logic       ready,
  output logic       serial_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - P_DATA_BITS);
  localparam logic [2:0] LAST_BIT  = 3'(P_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(P_STOP_BITS - 1);
  localparam logic       PAR_INV   = 1'(P_PARITY_ODD);
  localparam logic       PAR_EN    = 1'(P_PARITY_EN);

  function automatic logic frame_parity(input logic [7:0] data);
    return (^(data & DATA_MASK)) ^ PAR_INV;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       serial_q, serial_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       bit_end;

  // A tick landing on the acceptance edge is ignored because the counter only runs outside IDLE.
  assign bit_end = (state_q != S_IDLE) && x16_BAUD && (tick_q == 4'd15);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    done_d   = 1'b0;
    serial_d = 1'b1;

    if ((state_q != S_IDLE) && x16_BAUD) begin
      tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_START;
          shift_d = Di & DATA_MASK;
          par_d   = frame_parity(Di);
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          stop_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = 3'd0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register alongside it.
    case (state_d)
      S_IDLE:   serial_d = 1'b1;
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
      S_STOP:   serial_d = 1'b1;
      default:  serial_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      shift_q  <= 8'd0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 7O1) checked tick by tick
// against a frame model built from the byte and the frame format.
module tb_uart_tx;

  localparam int DB [3] = '{8, 8, 7};
  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int SB [3] = '{1, 2, 1};

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       x16_BAUD = 1'b0;
  logic [7:0] Di = 8'd0;
  logic [2:0] valid_v = 3'b000;
  logic [2:0] so_w, rdy_w, bsy_w, dn_w;

  int tests = 0;
  int fails = 0;
  int tick_period = 6;
  int tcnt = 0;

  always #5 CLK = ~CLK;

  // Tick source; period 1 holds x16_BAUD high continuously.
  always @(negedge CLK) begin
    if (tcnt + 1 >= tick_period) begin
      tcnt     <= 0;
      x16_BAUD <= 1'b1;
    end else begin
      tcnt     <= tcnt + 1;
      x16_BAUD <= 1'b0;
    end
  end

  uart_tx u0 (.CLK(CLK), .reset(reset), .x16_BAUD(x16_BAUD), .Di(Di), .valid(valid_v[0]),
              .ready(rdy_w[0]), .serial_out(so_w[0]), .busy(bsy_w[0]), .done(dn_w[0]));
  uart_tx #(.P_DATA_BITS(8), .P_STOP_BITS(2), .P_PARITY_EN(1), .P_PARITY_ODD(0)) u1 (
              .CLK(CLK), .reset(reset), .x16_BAUD(x16_BAUD), .Di(Di), .valid(valid_v[1]),
              .ready(rdy_w[1]), .serial_out(so_w[1]), .busy(bsy_w[1]), .done(dn_w[1]));
  uart_tx #(.P_DATA_BITS(7), .P_STOP_BITS(1), .P_PARITY_EN(1), .P_PARITY_ODD(1)) u2 (
              .CLK(CLK), .reset(reset), .x16_BAUD(x16_BAUD), .Di(Di), .valid(valid_v[2]),
              .ready(rdy_w[2]), .serial_out(so_w[2]), .busy(bsy_w[2]), .done(dn_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on instance id and checks the line after every counted tick.
  task automatic send_frame(input int id, input logic [7:0] b, input bit hold,
                            input logic [7:0] nb, input bit expect_now);
    logic exp_bits[$];
    logic par, expv, rdy_before, t;
    int   total, k, n, cyc;
    bit   early;
    exp_bits.push_back(1'b0);
    par = 1'b0;
    for (int i = 0; i < DB[id]; i++) begin
      exp_bits.push_back(b[i]);
      par ^= b[i];
    end
    if (PE[id] != 0) exp_bits.push_back(par ^ (PO[id] != 0));
    for (int i = 0; i < SB[id]; i++) exp_bits.push_back(1'b1);
    total = 16 * exp_bits.size();

    Di = b;
    valid_v[id] = 1'b1;
    n = 0;
    do begin
      rdy_before = rdy_w[id];
      @(posedge CLK);
      n++;
    end while (!rdy_before && n < 3000);
    chk("accept_timeout", {31'd0, rdy_before}, 32'd1);
    if (expect_now) chk("b2b_gap", n, 32'd1);
    #1;
    chk("start_line", {so_w[id], rdy_w[id], bsy_w[id]}, 32'b001);
    if (hold) begin
      Di = nb;
    end else begin
      valid_v[id] = 1'b0;
      Di = 8'($urandom);
    end

    k = 0; cyc = 0; early = 1'b0;
    while (k < total && cyc < 5000) begin
      @(posedge CLK);
      t = x16_BAUD;
      #1;
      cyc++;
      if (!hold) begin
        valid_v[id] = (k >= 40 && k < 42);
        if (valid_v[id]) Di = 8'hFF;
      end
      if (t) begin
        k++;
        expv = (k < total) ? exp_bits[k / 16] : 1'b1;
        chk($sformatf("line_tick%0d", k), {31'd0, so_w[id]}, {31'd0, expv});
      end
      if (k < total && dn_w[id]) early = 1'b1;
    end
    chk("frame_ticks", k, total);
    chk("no_early_done", {31'd0, early}, 32'd0);
    chk("done_pulse", {dn_w[id], rdy_w[id], bsy_w[id]}, 32'b110);
    if (tick_period == 1) chk("cont_len", cyc, total);
    if (!hold) begin
      @(posedge CLK);
      #1;
      chk("done_once", {dn_w[id], rdy_w[id], so_w[id]}, 32'b011);
    end
  endtask

  // Starts a frame on instance 0, resets it mid data bit 3, then checks recovery.
  task automatic mid_reset();
    int  k, cyc;
    logic t;
    Di = 8'($urandom);
    valid_v[0] = 1'b1;
    @(posedge CLK);
    #1;
    valid_v[0] = 1'b0;
    chk("rst_frame_start", {31'd0, bsy_w[0]}, 32'd1);
    k = 0; cyc = 0;
    while (k < 16 * 4 + 8 && cyc < 3000) begin
      @(posedge CLK);
      t = x16_BAUD;
      #1;
      cyc++;
      if (t) k++;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {so_w[0], rdy_w[0], bsy_w[0], dn_w[0]}, 32'b1100);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_no_done", {29'd0, dn_w}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_idle", {dn_w[0], so_w[0], rdy_w[0]}, 32'b011);
  endtask

  initial begin
    logic [7:0] rb;
    int rid;
    repeat (3) @(negedge CLK);
    chk("reset_state", {so_w, rdy_w, bsy_w, dn_w}, 32'hFC0);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge CLK);
      #1;
      chk("idle", {so_w, rdy_w, bsy_w, dn_w}, 32'hFC0);
    end

    tick_period = 6;
    send_frame(0, 8'h55, 1'b0, 8'h00, 1'b0);
    send_frame(1, 8'h07, 1'b0, 8'h00, 1'b0);
    send_frame(2, 8'h07, 1'b0, 8'h00, 1'b0);
    send_frame(0, 8'hA3, 1'b1, 8'h3C, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 8'h00, 1'b1);
    mid_reset();
    send_frame(0, 8'h81, 1'b0, 8'h00, 1'b0);
    send_frame(0, 8'h00, 1'b0, 8'h00, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 8'h00, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 8'h00, 1'b0);
    send_frame(0, 8'hC3, 1'b0, 8'h00, 1'b0);

    for (int r = 0; r < 8; r++) begin
      tick_period = $urandom_range(1, 9);
      rid = $urandom_range(0, 2);
      rb = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge CLK);
      #1;
      send_frame(rid, rb, 1'b0, 8'h00, 1'b0);
    end

    tick_period = 1;
    @(posedge CLK);
    #1;
    send_frame(0, 8'($urandom), 1'b0, 8'h00, 1'b0);
    send_frame(1, 8'($urandom), 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
